// File: rtl/pi_pkg.sv
// Shared definitions for the multichannel PI core: FSM states, channel-index
// sizing, default output clamp limits and the accumulator sizing rule.
package pi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MUL  = 3'd2,
        ST_SUM  = 3'd3,
        ST_SAT  = 3'd4
    } pi_state_e;

    localparam int PI_OUT_MIN = 0;
    localparam int PI_OUT_MAX = 3723;

    function automatic int ch_w(input int nch);
        return (nch <= 1) ? 1 : $clog2(nch);
    endfunction

    // Smallest accumulator that holds the sum of three full products plus history
    function automatic int acc_w_min(input int data_w, input int coef_w);
        return data_w + coef_w + 3;
    endfunction

endpackage

// File: rtl/pi_multichannel_core_if.sv
// Sample/result bus of the multichannel PI core. With PI_DTERM_EN defined
// the bus carries the extra derivative coefficient coef_a2.
interface pi_multichannel_core_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int CH_W   = 1
);
    logic                     sample_valid;
    logic                     sample_ready;
    logic [CH_W-1:0]          sample_ch;
    logic [DATA_W-1:0]        setpoint;
    logic [DATA_W-1:0]        feedback;
    logic signed [COEF_W-1:0] coef_a0;
    logic signed [COEF_W-1:0] coef_a1;
`ifdef PI_DTERM_EN
    logic signed [COEF_W-1:0] coef_a2;
`endif
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic [DATA_W-1:0]        out_data;
    logic                     sat_flag;
    logic                     err_ch;

    modport master (
        output sample_valid, sample_ch, setpoint, feedback, coef_a0, coef_a1,
`ifdef PI_DTERM_EN
        output coef_a2,
`endif
        input  sample_ready, out_valid, out_ch, out_data, sat_flag, err_ch
    );

    modport slave (
        input  sample_valid, sample_ch, setpoint, feedback, coef_a0, coef_a1,
`ifdef PI_DTERM_EN
        input  coef_a2,
`endif
        output sample_ready, out_valid, out_ch, out_data, sat_flag, err_ch
    );
endinterface

// File: rtl/pi_sat_clamp.sv
// Combinational clamp of a signed accumulator value into [OUT_MIN, OUT_MAX],
// flagging when the limit was applied. Shared with the DAC path.
module pi_sat_clamp
    import pi_pkg::*;
#(
    parameter int ACC_W   = 40,
    parameter int DATA_W  = 16,
    parameter int OUT_MIN = PI_OUT_MIN,
    parameter int OUT_MAX = PI_OUT_MAX
) (
    input  logic signed [ACC_W-1:0] value,
    output logic [DATA_W-1:0]       clamped,
    output logic                    sat
);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(OUT_MIN);
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(OUT_MAX);

    // Select lower limit, upper limit or pass-through
    always_comb begin
        if (value < MIN_V) begin
            clamped = DATA_W'(OUT_MIN);
            sat     = 1'b1;
        end else if (value > MAX_V) begin
            clamped = DATA_W'(OUT_MAX);
            sat     = 1'b1;
        end else begin
            clamped = value[DATA_W-1:0];
            sat     = 1'b0;
        end
    end
endmodule

// File: rtl/pi_multichannel_core.sv
// Time-multiplexed velocity-form PI loops sharing one datapath, with
// per-channel history and anti-windup. Optional macro PI_DTERM_EN adds a2*e[k-2].
module pi_multichannel_core
    import pi_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int COEF_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int NCH     = 2,
    parameter int ACC_W   = 40,
    parameter int OUT_MIN = PI_OUT_MIN,
    parameter int OUT_MAX = PI_OUT_MAX
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  clr_state,
    pi_multichannel_core_if.slave bus
);
    localparam int CH_W   = ch_w(NCH);
    localparam int PROD_W = COEF_W + DATA_W + 1;

    pi_state_e state_r, state_nxt_s;
    logic sample_ready_s, ch_ok_s, accept_s, reject_s;

    logic [CH_W-1:0]          ch_r;
    logic [DATA_W-1:0]        sp_r, fb_r, up_r;
    logic signed [COEF_W-1:0] a0_r, a1_r;
    logic signed [DATA_W:0]   e_r, ep_r;
    logic signed [ACC_W-1:0]  p0_r, p1_r, u_new_r;
    logic signed [DATA_W:0]   e_prev_r [NCH];
    logic [DATA_W-1:0]        u_prev_r [NCH];
`ifdef PI_DTERM_EN
    logic signed [COEF_W-1:0] a2_r;
    logic signed [DATA_W:0]   ep2_r;
    logic signed [ACC_W-1:0]  p2_r;
    logic signed [DATA_W:0]   e_prev2_r [NCH];
    logic [PROD_W-1:0]        p2_s;
`endif

    logic                    out_valid_r, sat_flag_r, err_ch_r;
    logic [CH_W-1:0]         out_ch_r;
    logic [DATA_W-1:0]       out_data_r, clamped_s;
    logic                    sat_s;
    logic [PROD_W-1:0]       p0_s, p1_s;
    logic signed [ACC_W-1:0] sum_s, delta_s, u_new_s;

    // Operands are sign-extended by hand so the unsigned product keeps correct low bits
    assign p0_s = {{(PROD_W-COEF_W){a0_r[COEF_W-1]}}, a0_r} * {{(PROD_W-DATA_W-1){e_r[DATA_W]}}, e_r};
    assign p1_s = {{(PROD_W-COEF_W){a1_r[COEF_W-1]}}, a1_r} * {{(PROD_W-DATA_W-1){ep_r[DATA_W]}}, ep_r};
`ifdef PI_DTERM_EN
    assign p2_s = {{(PROD_W-COEF_W){a2_r[COEF_W-1]}}, a2_r} * {{(PROD_W-DATA_W-1){ep2_r[DATA_W]}}, ep2_r};
    assign sum_s = p0_r + p1_r + p2_r;
`else
    assign sum_s = p0_r + p1_r;
`endif
    assign delta_s = sum_s >>> FRAC_W;
    assign u_new_s = $signed({{(ACC_W-DATA_W){1'b0}}, up_r}) + delta_s;

    pi_sat_clamp #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .OUT_MIN(OUT_MIN),
        .OUT_MAX(OUT_MAX)
    ) u_clamp (
        .value  (u_new_r),
        .clamped(clamped_s),
        .sat    (sat_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state; clr_state aborts any computation
    always_comb begin
        state_nxt_s = state_r;
        if (clr_state) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: state_nxt_s = accept_s ? ST_ERR : ST_IDLE;
                ST_ERR:  state_nxt_s = ST_MUL;
                ST_MUL:  state_nxt_s = ST_SUM;
                ST_SUM:  state_nxt_s = ST_SAT;
                ST_SAT:  state_nxt_s = ST_IDLE;
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: ready decode and accept/reject qualification
    always_comb begin
        sample_ready_s = (state_r == ST_IDLE);
        ch_ok_s        = (int'(bus.sample_ch) < NCH);
        accept_s       = sample_ready_s && bus.sample_valid && !clr_state && ch_ok_s;
        reject_s       = sample_ready_s && bus.sample_valid && !clr_state && !ch_ok_s;
    end

    // Datapath pipeline, channel histories and result registers
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            ch_r <= '0; sp_r <= '0; fb_r <= '0; up_r <= '0;
            a0_r <= '0; a1_r <= '0; e_r <= '0; ep_r <= '0;
            p0_r <= '0; p1_r <= '0; u_new_r <= '0;
            out_valid_r <= 1'b0; sat_flag_r <= 1'b0; err_ch_r <= 1'b0;
            out_ch_r <= '0; out_data_r <= '0;
            for (int i = 0; i < NCH; i++) begin
                e_prev_r[i] <= '0;
                u_prev_r[i] <= '0;
            end
`ifdef PI_DTERM_EN
            a2_r <= '0; ep2_r <= '0; p2_r <= '0;
            for (int i = 0; i < NCH; i++) e_prev2_r[i] <= '0;
`endif
        end else if (clr_state) begin
            out_valid_r <= 1'b0;
            err_ch_r    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                e_prev_r[i] <= '0;
                u_prev_r[i] <= '0;
            end
`ifdef PI_DTERM_EN
            for (int i = 0; i < NCH; i++) e_prev2_r[i] <= '0;
`endif
        end else begin
            out_valid_r <= 1'b0;
            err_ch_r    <= reject_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ch_r <= bus.sample_ch; sp_r <= bus.setpoint; fb_r <= bus.feedback;
                        a0_r <= bus.coef_a0;   a1_r <= bus.coef_a1;
`ifdef PI_DTERM_EN
                        a2_r <= bus.coef_a2;
`endif
                    end
                end
                ST_ERR: begin
                    e_r  <= $signed({1'b0, sp_r}) - $signed({1'b0, fb_r});
                    ep_r <= e_prev_r[ch_r];
                    up_r <= u_prev_r[ch_r];
`ifdef PI_DTERM_EN
                    ep2_r <= e_prev2_r[ch_r];
`endif
                end
                ST_MUL: begin
                    p0_r <= {{(ACC_W-PROD_W){p0_s[PROD_W-1]}}, p0_s};
                    p1_r <= {{(ACC_W-PROD_W){p1_s[PROD_W-1]}}, p1_s};
`ifdef PI_DTERM_EN
                    p2_r <= {{(ACC_W-PROD_W){p2_s[PROD_W-1]}}, p2_s};
`endif
                end
                ST_SUM: u_new_r <= u_new_s;
                ST_SAT: begin
                    // Storing the clamped value as history gives anti-windup
                    u_prev_r[ch_r] <= clamped_s;
                    e_prev_r[ch_r] <= e_r;
`ifdef PI_DTERM_EN
                    e_prev2_r[ch_r] <= ep_r;
`endif
                    out_data_r  <= clamped_s;
                    out_ch_r    <= ch_r;
                    sat_flag_r  <= sat_s;
                    out_valid_r <= 1'b1;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.sample_ready = sample_ready_s;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_ch       = out_ch_r;
    assign bus.out_data     = out_data_r;
    assign bus.sat_flag     = sat_flag_r;
    assign bus.err_ch       = err_ch_r;
endmodule
